// File: rtl/perf_counter_unit.sv
// Performance counters for cycles, retired instructions and I/D-cache activity.
// Counting freezes once Halt retires; a registered read port exposes counts and status.
module perf_counter_unit #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             reg_write,
    input  logic             mem_write,
    input  logic             halt,
    input  logic             icache_req,
    input  logic             icache_hit,
    input  logic             dcache_req,
    input  logic             dcache_hit,
    input  logic             clear,
    input  logic             rd_en,
    input  logic [2:0]       rd_sel,
    output logic [CNT_W-1:0] rd_data,
    output logic             rd_valid,
    output logic             halted
);

    localparam int unsigned NumCnt = 6;
    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic {StRun, StHalted} state_t;

    state_t             stateQ, stateD;
    logic               runEnQ;
    logic [CNT_W-1:0]   cntQ [NumCnt];
    logic [CNT_W-1:0]   cntD [NumCnt];
    logic [NumCnt-1:0]  ovfQ, ovfD;
    logic [NumCnt-1:0]  incVec;
    logic               countEn;
    logic [CNT_W-1:0]   statusWord;
    logic [CNT_W-1:0]   rdMux;
    logic [CNT_W-1:0]   rdDataQ;
    logic               rdValidQ;

    // Bit order matches ovf mapping: cycles, inst, icReq, icHit, dcReq, dcHit.
    assign incVec  = {dcache_hit, dcache_req, icache_hit, icache_req,
                      reg_write | mem_write | halt, 1'b1};
    assign countEn = runEnQ && (stateQ == StRun);

    always_comb begin
        stateD = stateQ;
        ovfD   = ovfQ;
        for (int i = 0; i < NumCnt; i++) begin
            cntD[i] = cntQ[i];
        end
        if (clear) begin
            stateD = StRun;
            ovfD   = '0;
            for (int i = 0; i < NumCnt; i++) begin
                cntD[i] = '0;
            end
        end else if (countEn) begin
            for (int i = 0; i < NumCnt; i++) begin
                if (incVec[i]) begin
                    if (cntQ[i] == CntMax) begin
                        ovfD[i] = 1'b1;
                    end else begin
                        cntD[i] = cntQ[i] + CntOne;
                    end
                end
            end
            if (halt) begin
                stateD = StHalted;
            end
        end
    end

    always_comb begin
        statusWord      = '0;
        statusWord[6:0] = {ovfQ, stateQ == StHalted};
    end

    always_comb begin
        rdMux = '0;
        unique case (rd_sel)
            3'd0:    rdMux = cntQ[0];
            3'd1:    rdMux = cntQ[1];
            3'd2:    rdMux = cntQ[2];
            3'd3:    rdMux = cntQ[3];
            3'd4:    rdMux = cntQ[4];
            3'd5:    rdMux = cntQ[5];
            3'd6:    rdMux = statusWord;
            default: rdMux = '0;
        endcase
    end

    // runEnQ delays counting by one edge so reset release is clock-aligned.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            runEnQ   <= 1'b0;
            stateQ   <= StRun;
            ovfQ     <= '0;
            rdDataQ  <= '0;
            rdValidQ <= 1'b0;
            for (int i = 0; i < NumCnt; i++) begin
                cntQ[i] <= '0;
            end
        end else begin
            runEnQ   <= 1'b1;
            stateQ   <= stateD;
            ovfQ     <= ovfD;
            rdValidQ <= rd_en;
            if (rd_en) begin
                rdDataQ <= rdMux;
            end
            for (int i = 0; i < NumCnt; i++) begin
                cntQ[i] <= cntD[i];
            end
        end
    end

    assign rd_data  = rdDataQ;
    assign rd_valid = rdValidQ;
    assign halted   = (stateQ == StHalted);

endmodule

// File: tb/tb_perf_counter_unit.sv
// Directed bench for perf_counter_unit; a 32-bit and an 8-bit instance share stimulus.
module tb_perf_counter_unit;

    logic        clk;
    logic        rst;
    logic        reg_write, mem_write, halt;
    logic        icache_req, icache_hit, dcache_req, dcache_hit;
    logic        clear, rd_en;
    logic [2:0]  rd_sel;
    logic [31:0] rdData32;
    logic        rdValid32, halted32;
    logic [7:0]  rdData8;
    logic        rdValid8, halted8;

    int total = 0;
    int bad   = 0;

    perf_counter_unit #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .reg_write(reg_write), .mem_write(mem_write), .halt(halt),
        .icache_req(icache_req), .icache_hit(icache_hit), .dcache_req(dcache_req),
        .dcache_hit(dcache_hit), .clear(clear), .rd_en(rd_en), .rd_sel(rd_sel),
        .rd_data(rdData32), .rd_valid(rdValid32), .halted(halted32)
    );

    perf_counter_unit #(.CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .reg_write(reg_write), .mem_write(mem_write), .halt(halt),
        .icache_req(icache_req), .icache_hit(icache_hit), .dcache_req(dcache_req),
        .dcache_hit(dcache_hit), .clear(clear), .rd_en(rd_en), .rd_sel(rd_sel),
        .rd_data(rdData8), .rd_valid(rdValid8), .halted(halted8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        reg_write = 0; mem_write = 0; halt = 0;
        icache_req = 0; icache_hit = 0; dcache_req = 0; dcache_hit = 0;
        clear = 0; rd_en = 0; rd_sel = 3'd0;
    endtask

    task automatic test_reset();
        rst = 0;
        idleInputs();
        repeat (2) tick();
        total++; if (rdData32 !== 32'd0) begin bad++; $display("FAIL reset_data got=%0d exp=0", rdData32); end
        total++; if (rdValid32 !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", rdValid32); end
        total++; if (halted32 !== 1'b0) begin bad++; $display("FAIL reset_halted got=%0b exp=0", halted32); end
        total++; if (rdData8 !== 8'd0) begin bad++; $display("FAIL reset_data8 got=%0d exp=0", rdData8); end
        rst = 1;
    endtask

    task automatic test_basic();
        tick(); // synchroniser edge, no count
        for (int c = 1; c <= 10; c++) begin
            reg_write = (c == 3 || c == 5 || c == 7);
            tick();
        end
        reg_write = 0;
        total++; if (rdValid32 !== 1'b0) begin bad++; $display("FAIL basic_novalid got=%0b exp=0", rdValid32); end
        rd_en = 1; rd_sel = 3'd0;
        tick();
        total++; if (rdValid32 !== 1'b1) begin bad++; $display("FAIL basic_valid0 got=%0b exp=1", rdValid32); end
        total++; if (rdData32 !== 32'd10) begin bad++; $display("FAIL basic_cycles got=%0d exp=10", rdData32); end
        rd_sel = 3'd1;
        tick();
        total++; if (rdValid32 !== 1'b1) begin bad++; $display("FAIL basic_valid1 got=%0b exp=1", rdValid32); end
        total++; if (rdData32 !== 32'd3) begin bad++; $display("FAIL basic_inst got=%0d exp=3", rdData32); end
        rd_en = 0;
        tick();
        total++; if (rdValid32 !== 1'b0) begin bad++; $display("FAIL basic_pulse got=%0b exp=0", rdValid32); end
        total++; if (rdData32 !== 32'd3) begin bad++; $display("FAIL basic_hold got=%0d exp=3", rdData32); end
    endtask

    task automatic test_halt();
        logic [31:0] expVals [7];
        expVals = '{32'd3, 32'd1, 32'd1, 32'd0, 32'd0, 32'd1, 32'd1};
        clear = 1; tick(); clear = 0;
        tick(); tick();
        total++; if (halted32 !== 1'b0) begin bad++; $display("FAIL halt_pre got=%0b exp=0", halted32); end
        reg_write = 1; mem_write = 1; halt = 1; icache_req = 1; dcache_hit = 1;
        tick();
        total++; if (halted32 !== 1'b1) begin bad++; $display("FAIL halt_state got=%0b exp=1", halted32); end
        halt = 0; mem_write = 0;
        icache_hit = 1; dcache_req = 1;
        repeat (5) tick();
        idleInputs();
        for (int s = 0; s < 7; s++) begin
            rd_en = 1; rd_sel = 3'(s);
            tick();
            total++;
            if (rdValid32 !== 1'b1 || rdData32 !== expVals[s]) begin
                bad++;
                $display("FAIL halt_sel%0d got=%0d/v%0b exp=%0d/v1", s, rdData32, rdValid32, expVals[s]);
            end
        end
        rd_en = 0;
    endtask

    task automatic test_cache();
        logic [2:0]  sels [5];
        logic [31:0] expVals [5];
        sels    = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
        expVals = '{32'd20, 32'd15, 32'd4, 32'd3, 32'd24};
        clear = 1; tick(); clear = 0;
        total++; if (halted32 !== 1'b0) begin bad++; $display("FAIL cache_unhalt got=%0b exp=0", halted32); end
        for (int i = 0; i < 20; i++) begin
            icache_req = 1;
            icache_hit = (i < 15);
            dcache_req = (i % 5 == 0);
            dcache_hit = (i >= 1 && i <= 3);
            tick();
        end
        idleInputs();
        for (int k = 0; k < 5; k++) begin
            rd_en = 1; rd_sel = sels[k];
            tick();
            total++;
            if (rdData32 !== expVals[k]) begin
                bad++;
                $display("FAIL cache_sel%0d got=%0d exp=%0d", sels[k], rdData32, expVals[k]);
            end
        end
        rd_en = 0;
    endtask

    task automatic test_saturate();
        clear = 1; tick(); clear = 0;
        repeat (300) tick();
        rd_en = 1; rd_sel = 3'd0;
        tick();
        total++; if (rdData8 !== 8'd255) begin bad++; $display("FAIL sat_cycles8 got=%0d exp=255", rdData8); end
        total++; if (rdData32 !== 32'd300) begin bad++; $display("FAIL sat_cycles32 got=%0d exp=300", rdData32); end
        rd_sel = 3'd6;
        tick();
        total++; if (rdData8 !== 8'h02) begin bad++; $display("FAIL sat_status8 got=%0h exp=2", rdData8); end
        total++; if (rdData32 !== 32'h0) begin bad++; $display("FAIL sat_status32 got=%0h exp=0", rdData32); end
        rd_sel = 3'd1;
        tick();
        total++; if (rdData8 !== 8'd0) begin bad++; $display("FAIL sat_inst8 got=%0d exp=0", rdData8); end
        rd_sel = 3'd2;
        tick();
        total++; if (rdData8 !== 8'd0) begin bad++; $display("FAIL sat_icreq8 got=%0d exp=0", rdData8); end
        rd_en = 0;
    endtask

    task automatic test_clear_halt();
        clear = 1; halt = 1; rd_en = 1; rd_sel = 3'd6;
        tick();
        total++; if (rdData8 !== 8'h02) begin bad++; $display("FAIL ch_preclear got=%0h exp=2", rdData8); end
        total++; if (halted32 !== 1'b0) begin bad++; $display("FAIL ch_halted got=%0b exp=0", halted32); end
        total++; if (halted8 !== 1'b0) begin bad++; $display("FAIL ch_halted8 got=%0b exp=0", halted8); end
        clear = 0; halt = 0; rd_sel = 3'd0;
        tick();
        total++; if (rdData32 !== 32'd0) begin bad++; $display("FAIL ch_zero got=%0d exp=0", rdData32); end
        tick();
        total++; if (rdData32 !== 32'd1) begin bad++; $display("FAIL ch_resume got=%0d exp=1", rdData32); end
        rd_sel = 3'd6;
        tick();
        total++; if (rdData8 !== 8'h00) begin bad++; $display("FAIL ch_status8 got=%0h exp=0", rdData8); end
        total++; if (rdData32 !== 32'h0) begin bad++; $display("FAIL ch_status32 got=%0h exp=0", rdData32); end
        rd_en = 0;
    endtask

    task automatic test_reset_mid_read();
        clear = 1; tick(); clear = 0;
        rd_en = 1; rd_sel = 3'd0;
        tick(); tick(); tick();
        total++; if (rdData32 !== 32'd2) begin bad++; $display("FAIL mr_before got=%0d exp=2", rdData32); end
        #2 rst = 0;
        #1;
        total++; if (rdValid32 !== 1'b0) begin bad++; $display("FAIL mr_valid got=%0b exp=0", rdValid32); end
        total++; if (rdData32 !== 32'd0) begin bad++; $display("FAIL mr_data got=%0d exp=0", rdData32); end
        total++; if (rdValid8 !== 1'b0) begin bad++; $display("FAIL mr_valid8 got=%0b exp=0", rdValid8); end
        tick();
        total++; if (rdValid32 !== 1'b0) begin bad++; $display("FAIL mr_held got=%0b exp=0", rdValid32); end
        rst = 1;
        tick();
        total++; if (rdValid32 !== 1'b1 || rdData32 !== 32'd0) begin
            bad++; $display("FAIL mr_first got=%0d/v%0b exp=0/v1", rdData32, rdValid32);
        end
        tick();
        total++; if (rdData32 !== 32'd0) begin bad++; $display("FAIL mr_sync got=%0d exp=0", rdData32); end
        tick();
        total++; if (rdData32 !== 32'd1) begin bad++; $display("FAIL mr_count got=%0d exp=1", rdData32); end
        rd_en = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_halt();
        test_cache();
        test_saturate();
        test_clear_halt();
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/perf_counter_unit.md
# perf_counter_unit

Hardware performance-counter block that sits downstream of the processor's writeback and cache interfaces. Each cycle it consumes the same retirement and cache-activity strobes that the processor bench samples, and accumulates cycle, instruction, I-cache and D-cache request/hit counts. Counting freezes when Halt retires. A registered read port exposes the counts so that on-chip software or a debug shell can read the statistics without a simulator.

## Interface
- CNT_W, 32: width of every counter and of rd_data; legal range 8–32.
- clk  in  1  processor clock, rising-edge.
- rst  in  1  asynchronous, active-low reset.
- reg_write  in  1  register-file write retiring this cycle (already stall-qualified).
- mem_write  in  1  data-memory store retiring this cycle.
- halt  in  1  Halt instruction retiring this cycle.
- icache_req  in  1  valid I-cache request this cycle.
- icache_hit  in  1  valid I-cache hit this cycle.
- dcache_req  in  1  valid D-cache read or write request this cycle.
- dcache_hit  in  1  valid D-cache hit this cycle.
- clear  in  1  synchronous clear of all counters and status; returns the block to RUN.
- rd_en  in  1  read request.
- rd_sel  in  3  0 cycles, 1 inst, 2 icache_req, 3 icache_hit, 4 dcache_req, 5 dcache_hit, 6 status, 7 reserved (reads 0).
- rd_data  out  CNT_W  read data, valid when rd_valid is high.
- rd_valid  out  1  one-cycle pulse, one cycle after rd_en.
- halted  out  1  high while in the HALTED state.

## Operation
- Two states:
  - RUN is entered on reset and after clear.
  - HALTED is entered from RUN at the edge that samples halt=1.
  - The only exit from HALTED is clear (or reset).
- In RUN, on each rising edge:
  - cycles increments by 1.
  - inst increments by 1 if reg_write, mem_write or halt is high; a cycle with several of these high counts once.
  - Each cache counter increments by 1 when its own strobe is high. A hit strobe with no matching req is still counted; the strobes are independent.
- The halt cycle is fully counted: cycles, inst and any cache strobes in that cycle. After that cycle, no counter changes while in HALTED.
- Counters saturate at 2^CNT_W−1 and do not wrap. The first increment attempted at the maximum sets a sticky ovf bit for that counter.
- ovf bit mapping: ovf[0] cycles, ovf[1] inst, ovf[2] icache_req, ovf[3] icache_hit, ovf[4] dcache_req, ovf[5] dcache_hit.
- Status word (rd_sel=6): bit0 = halted, bits6:1 = ovf[5:0], upper bits 0.
- Priority within a cycle: clear beats halt and beats increments. With clear=1 and halt=1 together, the result is all counters 0, ovf 0, state RUN.

## Timing
- Reset values:
  - rd_data = 0, rd_valid = 0, halted = 0.
  - All counters and ovf bits = 0; state = RUN.
- Reset is asynchronous on assertion. Internal release is synchronised to clk; the first count happens at the second rising edge after rst deasserts.
- Reset mid-run discards all counts immediately; there is no partial-count retention.
- Read latency is 1 cycle:
  - rd_en=1 sampled at edge E produces rd_valid=1 and rd_data for the following cycle.
  - rd_data is the register value held before edge E, so the increment applied at edge E is excluded.
  - rd_valid=0 in any cycle not following an rd_en.
- rd_data holds its last value while rd_valid=0.
- Back-to-back reads: one per cycle, no bubbles.
- Read in the same cycle as clear returns the pre-clear value.
- halted rises in the cycle after the halt edge, together with the state change.

## Test plan
- Reset, then 10 RUN cycles with reg_write=1 on cycles 3, 5 and 7, then read sel 0 and sel 1 → 10 and 3. rd_valid pulses exactly one cycle after each rd_en.
- Same cycle with reg_write=1, mem_write=1 and halt=1, followed by 5 further cycles of strobes → inst +1 only. halted=1. cycles and all cache counters frozen; sel 6 reads 0x1.
- Over 20 cycles: icache_req=1 every cycle, icache_hit=1 on 15 cycles, dcache_req=1 on 4 cycles, dcache_hit=1 on 3 cycles → reads 20, 15, 4, 3.
- CNT_W=8: run 300 cycles → cycles reads 255 and sel 6 bit1 = 1; all other counters unaffected.
- clear and halt asserted together in the same cycle → halted stays 0, all reads 0, and counting resumes on the next edge.
- rst pulled low mid-read (rd_en high) → rd_valid=0, rd_data=0 and all counters 0 immediately, with no waiting for a clock edge.
